// File: rtl/regfile_write_arbiter_pkg.sv
// Shared constants and types for the register-file write arbiter.
package regfile_write_arbiter_pkg;

    localparam int               REG_ADDR_WIDTH = 5;
    localparam int               XLEN           = 32;
    localparam logic [4:0]       REG_ZERO       = 5'd0;

    typedef enum logic {
        ST_HOLD = 1'b0,
        ST_RUN  = 1'b1
    } arb_state_e;

    // Width needed to hold values 0..n-1, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Requester and write-port bundle of the register-file write arbiter.
interface regfile_write_arbiter_if #(
    parameter int NUM_REQ    = 3,
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic                          freeze;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          wr_en;
    logic [ADDR_WIDTH-1:0]         wr_addr;
    logic [DATA_WIDTH-1:0]         wr_data;
    logic                          busy;

    // Requesters and the debug halt drive this side.
    modport master (
        output req_valid, req_addr, req_data, freeze,
        input  req_ready, wr_en, wr_addr, wr_data, busy
    );

    // The arbiter sits on this side.
    modport slave (
        input  req_valid, req_addr, req_data, freeze,
        output req_ready, wr_en, wr_addr, wr_data, busy
    );
endinterface

// File: rtl/regfile_write_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: first set request after i_ptr wins.
module rr_priority_picker #(
    parameter int NUM_REQ = 3,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [PTR_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_grant
);
    int   w_idx;
    logic w_found;

    // Walk the requests from i_ptr+1 around to i_ptr and grant the first one set.
    always_comb begin
        o_grant = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = (int'(i_ptr) + k) % NUM_REQ;
            if (!w_found && i_req[w_idx]) begin
                o_grant[w_idx] = 1'b1;
                w_found        = 1'b1;
            end
        end
    end
endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port among NUM_REQ writers,
// with a post-reset hold window and a registered write port.
module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter int NUM_REQ     = 3,
    parameter int ADDR_WIDTH  = REG_ADDR_WIDTH,
    parameter int DATA_WIDTH  = XLEN,
    parameter int HOLD_CYCLES = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    regfile_write_arbiter_if.slave  bus
);
    localparam int PTR_W = idx_width(NUM_REQ);
    localparam int CNT_W = idx_width(HOLD_CYCLES + 1);

    arb_state_e             r_state;
    arb_state_e             w_state_nxt;
    logic [CNT_W-1:0]       r_hold_cnt;
    logic [CNT_W-1:0]       w_hold_cnt_nxt;
    logic [PTR_W-1:0]       r_ptr;
    logic [NUM_REQ-1:0]     w_pick;
    logic [NUM_REQ-1:0]     w_ready;
    logic                   w_hs;
    logic [PTR_W-1:0]       w_win;
    logic [ADDR_WIDTH-1:0]  w_win_addr;
    logic [DATA_WIDTH-1:0]  w_win_data;
    logic                   r_wr_en;
    logic [ADDR_WIDTH-1:0]  r_wr_addr;
    logic [DATA_WIDTH-1:0]  r_wr_data;

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_picker (
        .i_req   (bus.req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_pick)
    );

    // State and hold counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_HOLD;
            r_hold_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_hold_cnt <= w_hold_cnt_nxt;
        end
    end

    // Next state: count out the hold window, then stay in RUN until reset.
    always_comb begin
        w_state_nxt    = r_state;
        w_hold_cnt_nxt = r_hold_cnt;
        unique case (r_state)
            ST_HOLD: begin
                w_hold_cnt_nxt = r_hold_cnt + 1'b1;
                if (r_hold_cnt == CNT_W'(HOLD_CYCLES - 1))
                    w_state_nxt = ST_RUN;
            end
            ST_RUN:  w_state_nxt = ST_RUN;
            default: w_state_nxt = ST_HOLD;
        endcase
    end

    // Grants are only visible in RUN with no debug freeze; freeze acts in the same cycle.
    assign w_ready = (r_state == ST_RUN && !bus.freeze) ? w_pick : '0;
    assign w_hs    = |(bus.req_valid & w_ready);

    // Encode the one-hot grant and select the winner's address and data.
    always_comb begin
        w_win      = '0;
        w_win_addr = '0;
        w_win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_ready[i]) begin
                w_win      = PTR_W'(i);
                w_win_addr = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                w_win_data = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Round-robin pointer remembers the last winner; it holds when nothing is granted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_ptr <= PTR_W'(NUM_REQ - 1);
        else if (w_hs)
            r_ptr <= w_win;
    end

    // Registered write port; x0 writes are consumed but never enabled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_wr_en <= w_hs && (w_win_addr != ADDR_WIDTH'(REG_ZERO));
            if (w_hs) begin
                r_wr_addr <= w_win_addr;
                r_wr_data <= w_win_data;
            end
        end
    end

    assign bus.req_ready = w_ready;
    assign bus.wr_en     = r_wr_en;
    assign bus.wr_addr   = r_wr_addr;
    assign bus.wr_data   = r_wr_data;
    assign bus.busy      = (r_state == ST_HOLD);
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomized and directed bench for regfile_write_arbiter against a behavioural model.
module tb_regfile_write_arbiter;
    localparam int N  = 3;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam int HC = 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    regfile_write_arbiter_if #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    regfile_write_arbiter #(
        .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .HOLD_CYCLES(HC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Model: cycles of hold left, last winner, expected registered outputs.
    int              m_hold;
    int              m_ptr;
    logic            m_en;
    logic [AW-1:0]   m_addr;
    logic [DW-1:0]   m_data;
    int              last_win;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_hold = HC;
        m_ptr  = N - 1;
        m_en   = 1'b0;
        m_addr = '0;
        m_data = '0;
    endtask

    // One clock: drive inputs, check against model at negedge, advance model, return at posedge+1.
    task automatic cycle(input logic [N-1:0] v, input logic [N*AW-1:0] a,
                         input logic [N*DW-1:0] d, input logic f);
        int            win;
        logic [N-1:0]  exp_ready;
        bus.req_valid = v;
        bus.req_addr  = a;
        bus.req_data  = d;
        bus.freeze    = f;
        @(negedge clk);
        win = -1;
        if (m_hold == 0 && !f) begin
            for (int k = 1; k <= N; k++) begin
                int i;
                i = (m_ptr + k) % N;
                if (win < 0 && v[i]) win = i;
            end
        end
        exp_ready = '0;
        if (win >= 0) exp_ready[win] = 1'b1;
        chk("req_ready", 64'(bus.req_ready), 64'(exp_ready));
        chk("wr_en",     64'(bus.wr_en),     64'(m_en));
        chk("wr_addr",   64'(bus.wr_addr),   64'(m_addr));
        chk("wr_data",   64'(bus.wr_data),   64'(m_data));
        chk("busy",      64'(bus.busy),      64'(m_hold > 0));
        if (m_hold > 0) m_hold--;
        last_win = win;
        if (win >= 0) begin
            m_ptr  = win;
            m_addr = a[win*AW +: AW];
            m_data = d[win*DW +: DW];
            m_en   = (m_addr != 0);
        end else begin
            m_en = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rst_seq();
        rst           = 1'b0;
        bus.req_valid = '0;
        bus.req_addr  = '0;
        bus.req_data  = '0;
        bus.freeze    = 1'b0;
        model_reset();
        repeat (3) begin
            @(negedge clk);
            chk("rst_wr_en", 64'(bus.wr_en), 64'd0);
            chk("rst_busy",  64'(bus.busy),  64'd1);
            chk("rst_ready", 64'(bus.req_ready), 64'd0);
        end
        chk("rst_wr_addr", 64'(bus.wr_addr), 64'd0);
        chk("rst_wr_data", 64'(bus.wr_data), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    logic [N*AW-1:0] ra;
    logic [N*DW-1:0] rd;
    logic [N-1:0]    rv;
    logic            rf;

    initial begin
        rst = 1'b0;
        last_win = -1;

        // Directed 1: lone requester 0 right after reset release.
        rst_seq();
        ra = {5'd3, 5'd2, 5'd1};
        rd = {32'hC, 32'hB, 32'hA};
        cycle(3'b001, ra, rd, 1'b0);
        chk("t1_hold_no_grant", 64'(last_win + 1), 64'd0);
        cycle(3'b001, ra, rd, 1'b0);
        chk("t1_grant0", 64'(last_win), 64'd0);
        chk("t1_wr_en", 64'(bus.wr_en), 64'd1);
        cycle(3'b001, ra, rd, 1'b0);
        chk("t1_back_to_back", 64'(last_win), 64'd0);

        // Directed 2: requester 1 alone.
        ra = {5'd0, 5'd5, 5'd0};
        rd = {32'h0, 32'hDEADBEEF, 32'h0};
        cycle(3'b010, ra, rd, 1'b0);
        chk("t2_wr_en",   64'(bus.wr_en),   64'd1);
        chk("t2_wr_addr", 64'(bus.wr_addr), 64'd5);
        chk("t2_wr_data", 64'(bus.wr_data), 64'hDEADBEEF);

        // Directed 3: all valid from reset, strict rotation.
        rst_seq();
        ra = {5'd3, 5'd2, 5'd1};
        rd = {32'h33, 32'h22, 32'h11};
        cycle(3'b111, ra, rd, 1'b0);
        for (int k = 0; k < 6; k++) begin
            cycle(3'b111, ra, rd, 1'b0);
            chk("t3_order", 64'(last_win), 64'(k % 3));
            chk("t3_pulse", 64'(bus.wr_en), 64'd1);
        end

        // Directed 4: write to x0 from requester 2.
        ra = {5'd0, 5'd0, 5'd0};
        rd = {32'h1234, 32'h0, 32'h0};
        cycle(3'b100, ra, rd, 1'b0);
        chk("t4_grant2", 64'(last_win), 64'd2);
        chk("t4_wr_en",  64'(bus.wr_en), 64'd0);
        chk("t4_wr_data", 64'(bus.wr_data), 64'h1234);

        // Directed 5: freeze blocks grants; release resumes after last winner.
        ra = {5'd7, 5'd6, 5'd4};
        rd = {32'h77, 32'h66, 32'h44};
        cycle(3'b001, ra, rd, 1'b0);
        chk("t5_pre", 64'(last_win), 64'd0);
        repeat (4) begin
            cycle(3'b111, ra, rd, 1'b1);
            chk("t5_frozen_ready", 64'(bus.req_ready), 64'd0);
        end
        chk("t5_frozen_wr_en", 64'(bus.wr_en), 64'd0);
        cycle(3'b111, ra, rd, 1'b0);
        chk("t5_resume", 64'(last_win), 64'd1);

        // Directed 6: async reset right after a handshake.
        cycle(3'b100, ra, rd, 1'b0);
        chk("t6_wr_en_before", 64'(bus.wr_en), 64'd1);
        #2 rst = 1'b0;
        #1;
        chk("t6_wr_en_async", 64'(bus.wr_en), 64'd0);
        chk("t6_busy_async",  64'(bus.busy),  64'd1);
        rst_seq();
        cycle(3'b111, ra, rd, 1'b0);
        chk("t6_hold_again", 64'(last_win + 1), 64'd0);

        // Random traffic.
        for (int c = 0; c < 400; c++) begin
            rv = N'($urandom);
            rf = ($urandom_range(7) == 0);
            for (int i = 0; i < N; i++) begin
                ra[i*AW +: AW] = ($urandom_range(3) == 0) ? '0 : AW'($urandom);
                rd[i*DW +: DW] = $urandom;
            end
            cycle(rv, ra, rd, rf);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
